// File: rtl/channel_window_averager.sv
// channel_window_averager
//   Per-channel sliding-window accumulator. Each accepted tagged sample updates
//   its channel's history ring, running sum and fill count, then produces one
//   result beat (sum, floor(sum/WINDOW), fill, full) on a single-entry output
//   register with a valid/ready handshake.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   clear             synchronous flush of all channel state (not chan_err)
//   in_valid/ready    input handshake; in_channel + in_sample form the payload
//   out_valid/ready   output handshake
//   out_channel       channel of the result beat
//   out_sum/out_avg   windowed sum and sum divided by WINDOW
//   out_fill/out_full samples in the window and window-full flag
//   chan_err          sticky: a sample for a non-existent channel was accepted
module channel_window_averager #(
  parameter int unsigned NUM_CHANNELS = 14,
  parameter int unsigned SAMPLE_BITS  = 8,
  parameter int unsigned WINDOW       = 10,
  localparam int unsigned CH_BITS     = $clog2(NUM_CHANNELS),
  localparam int unsigned SUM_BITS    = SAMPLE_BITS + $clog2(WINDOW),
  localparam int unsigned FILL_BITS   = $clog2(WINDOW + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH_BITS-1:0]     in_channel,
  input  logic [SAMPLE_BITS-1:0] in_sample,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH_BITS-1:0]     out_channel,
  output logic [SUM_BITS-1:0]    out_sum,
  output logic [SAMPLE_BITS-1:0] out_avg,
  output logic [FILL_BITS-1:0]   out_fill,
  output logic                   out_full,
  output logic                   chan_err
);

  localparam int unsigned WP_BITS = $clog2(WINDOW);

  // Per-channel state
  logic [SAMPLE_BITS-1:0] hist_q [NUM_CHANNELS][WINDOW];
  logic [WP_BITS-1:0]     wp_q   [NUM_CHANNELS];
  logic [FILL_BITS-1:0]   fill_q [NUM_CHANNELS];
  logic [SUM_BITS-1:0]    sum_q  [NUM_CHANNELS];

  // Output register
  logic                   out_valid_q;
  logic [CH_BITS-1:0]     out_channel_q;
  logic [SUM_BITS-1:0]    out_sum_q;
  logic [SAMPLE_BITS-1:0] out_avg_q;
  logic [FILL_BITS-1:0]   out_fill_q;
  logic                   out_full_q;
  logic                   chan_err_q;

  logic                   chan_ok;
  logic                   accept;
  logic                   upd;
  logic [CH_BITS-1:0]     ch_idx;
  logic [WP_BITS-1:0]     cur_wp;
  logic [FILL_BITS-1:0]   cur_fill;
  logic                   cur_full;
  logic [SAMPLE_BITS-1:0] oldest;
  logic [SUM_BITS-1:0]    sum_d;
  logic [FILL_BITS-1:0]   fill_d;
  logic [WP_BITS-1:0]     wp_d;
  logic [SAMPLE_BITS-1:0] avg_d;

  always_comb begin
    in_ready = !reset && !clear && (!out_valid_q || out_ready);
    chan_ok  = 32'(in_channel) < NUM_CHANNELS;
    accept   = in_valid && in_ready;
    upd      = accept && chan_ok;
    // Keep array indexing in range even when the offered channel is bogus.
    ch_idx   = chan_ok ? in_channel : '0;
    cur_wp   = wp_q[ch_idx];
    cur_fill = fill_q[ch_idx];
    cur_full = (cur_fill == FILL_BITS'(WINDOW));
    // Until the window is full the slot under wp holds stale data; treat it as 0.
    oldest   = cur_full ? hist_q[ch_idx][cur_wp] : '0;
    sum_d    = sum_q[ch_idx] - SUM_BITS'(oldest) + SUM_BITS'(in_sample);
    fill_d   = cur_full ? cur_fill : cur_fill + 1'b1;
    wp_d     = (cur_wp == WP_BITS'(WINDOW - 1)) ? '0 : cur_wp + 1'b1;
    avg_d    = SAMPLE_BITS'(sum_d / SUM_BITS'(WINDOW));
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        wp_q[i]   <= '0;
        fill_q[i] <= '0;
        sum_q[i]  <= '0;
      end
    end else if (upd) begin
      wp_q[ch_idx]   <= wp_d;
      fill_q[ch_idx] <= fill_d;
      sum_q[ch_idx]  <= sum_d;
    end
  end

  // History needs no reset: fill gates every read of it.
  always_ff @(posedge clk) begin
    if (upd) begin
      hist_q[ch_idx][cur_wp] <= in_sample;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      out_sum_q     <= '0;
      out_avg_q     <= '0;
      out_fill_q    <= '0;
      out_full_q    <= 1'b0;
      chan_err_q    <= 1'b0;
    end else if (clear) begin
      out_valid_q <= 1'b0;
    end else begin
      if (upd) begin
        out_valid_q   <= 1'b1;
        out_channel_q <= ch_idx;
        out_sum_q     <= sum_d;
        out_avg_q     <= avg_d;
        out_fill_q    <= fill_d;
        out_full_q    <= (fill_d == FILL_BITS'(WINDOW));
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept && !chan_ok) begin
        chan_err_q <= 1'b1;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_channel = out_channel_q;
  assign out_sum     = out_sum_q;
  assign out_avg     = out_avg_q;
  assign out_fill    = out_fill_q;
  assign out_full    = out_full_q;
  assign chan_err    = chan_err_q;

endmodule

// File: tb/tb_channel_window_averager.sv
// Self-checking bench for channel_window_averager: directed table and corner
// sequences plus randomized traffic, all compared against a queue-based model.
module tb_channel_window_averager;

  localparam int NCH = 14;
  localparam int WIN = 10;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_channel;
  logic [7:0]  in_sample;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_channel;
  logic [11:0] out_sum;
  logic [7:0]  out_avg;
  logic [3:0]  out_fill;
  logic        out_full;
  logic        chan_err;

  channel_window_averager dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_channel (in_channel),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_channel(out_channel),
    .out_sum    (out_sum),
    .out_avg    (out_avg),
    .out_fill   (out_fill),
    .out_full   (out_full),
    .chan_err   (chan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: each channel's window is simply a queue of its last samples.
  int q [NCH][$];
  bit e_valid;
  bit e_err;
  int e_ch, e_sum, e_fill;

  function automatic void model_clear();
    for (int c = 0; c < NCH; c++) q[c].delete();
  endfunction

  function automatic void model_push(int ch, int s);
    q[ch].push_back(s);
    if (q[ch].size() > WIN) void'(q[ch].pop_front());
    e_sum = 0;
    for (int k = 0; k < q[ch].size(); k++) e_sum += q[ch][k];
    e_fill = q[ch].size();
    e_ch   = ch;
  endfunction

  // One clock: check in_ready, clock the DUT, advance the model, check outputs.
  task automatic cycle();
    bit exp_rdy, acc;
    int ch;
    exp_rdy = !reset && !clear && (!e_valid || out_ready);
    #1;
    chk("in_ready", in_ready, exp_rdy);
    acc = in_valid && exp_rdy;
    ch  = in_channel;
    @(posedge clk);
    if (reset || clear) begin
      model_clear();
      e_valid = 0;
      if (reset) e_err = 0;
    end else if (acc) begin
      if (ch < NCH) begin
        model_push(ch, in_sample);
        e_valid = 1;
      end else begin
        e_err = 1;
        if (out_ready) e_valid = 0;
      end
    end else if (out_ready) begin
      e_valid = 0;
    end
    #1;
    chk("out_valid", out_valid, e_valid);
    chk("chan_err", chan_err, e_err);
    if (e_valid) begin
      chk("out_channel", out_channel, e_ch);
      chk("out_sum", out_sum, e_sum);
      chk("out_avg", out_avg, e_sum / WIN);
      chk("out_fill", out_fill, e_fill);
      chk("out_full", out_full, e_fill == WIN);
    end
  endtask

  task automatic send(int ch, int s);
    in_valid   = 1;
    in_channel = 4'(ch);
    in_sample  = 8'(s);
    out_ready  = 1;
    cycle();
    in_valid   = 0;
  endtask

  typedef struct {
    int ch;
    int s;
    int sum;
    int avg;
    int fill;
    bit full;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{3, 1,  1, 0,  1, 0};
    tbl[1]  = '{3, 2,  3, 0,  2, 0};
    tbl[2]  = '{3, 3,  6, 0,  3, 0};
    tbl[3]  = '{3, 4, 10, 1,  4, 0};
    tbl[4]  = '{3, 5, 15, 1,  5, 0};
    tbl[5]  = '{3, 6, 21, 2,  6, 0};
    tbl[6]  = '{3, 7, 28, 2,  7, 0};
    tbl[7]  = '{3, 8, 36, 3,  8, 0};
    tbl[8]  = '{3, 9, 45, 4,  9, 0};
    tbl[9]  = '{3, 10, 55, 5, 10, 1};
    tbl[10] = '{3, 11, 65, 6, 10, 1};
    tbl[11] = '{3, 12, 75, 7, 10, 1};

    e_valid = 0; e_err = 0; e_ch = 0; e_sum = 0; e_fill = 0;
    reset = 1; clear = 0; in_valid = 1; in_channel = 4'd1; in_sample = 8'd5; out_ready = 1;

    // Reset held two cycles with a sample offered
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_avg", out_avg, 0);
      chk("rst_out_fill", out_fill, 0);
      chk("rst_out_full", out_full, 0);
      chk("rst_out_channel", out_channel, 0);
    end
    reset = 0; in_valid = 0;
    cycle();

    // Fill and wrap on channel 3
    foreach (tbl[i]) begin
      send(tbl[i].ch, tbl[i].s);
      chk("tbl_sum", out_sum, tbl[i].sum);
      chk("tbl_avg", out_avg, tbl[i].avg);
      chk("tbl_fill", out_fill, tbl[i].fill);
      chk("tbl_full", out_full, tbl[i].full);
    end

    // Extremes and channel isolation
    for (int i = 0; i < WIN; i++) begin
      send(0, 255);
      if (i == WIN - 1) begin
        chk("ext_ch0_sum", out_sum, 2550);
        chk("ext_ch0_avg", out_avg, 255);
        chk("ext_ch0_full", out_full, 1);
      end
      send(13, 0);
      if (i == WIN - 1) chk("ext_ch13_sum", out_sum, 0);
    end
    send(1, 7);
    chk("ext_ch1_sum", out_sum, 7);
    chk("ext_ch1_fill", out_fill, 1);

    // Backpressure
    out_ready = 1;
    cycle();
    in_valid = 1; in_channel = 4'd2; in_sample = 8'd10; out_ready = 0;
    cycle();
    in_sample = 8'd20;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_hold_sum", out_sum, 10);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1;
    cycle();
    chk("bp_release_sum", out_sum, 30);
    in_valid = 0;

    // Bad channel, then traffic on channel 5
    send(14, 99);
    chk("bad_no_valid", out_valid, 0);
    chk("bad_err", chan_err, 1);
    send(5, 40);
    send(5, 2);
    chk("bad_ch5_sum", out_sum, 42);
    chk("bad_err_sticky", chan_err, 1);

    // Clear mid-window on channel 4
    for (int i = 0; i < 5; i++) send(4, 3 * i + 1);
    in_valid = 1; in_channel = 4'd4; in_sample = 8'd8; out_ready = 1; clear = 1;
    cycle();
    chk("clr_no_valid", out_valid, 0);
    chk("clr_err_kept", chan_err, 1);
    clear = 0;
    send(4, 8);
    chk("clr_sum", out_sum, 8);
    chk("clr_fill", out_fill, 1);
    chk("clr_full", out_full, 0);

    // Randomized traffic with backpressure, bad channels and occasional clears
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_channel = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(14, 15))
                 : ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 2))
                 : 4'($urandom_range(0, 13));
      in_sample  = 8'($urandom_range(0, 255));
      out_ready  = ($urandom_range(0, 3) != 0);
      clear      = ($urandom_range(0, 47) == 0);
      cycle();
    end
    clear = 0; in_valid = 0; out_ready = 1;
    cycle();

    // Only reset clears chan_err
    reset = 1;
    cycle();
    chk("final_err_cleared", chan_err, 0);
    reset = 0;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/channel_window_averager.md
# channel_window_averager

Downstream consumer of the per-channel sample buffer stage. It accepts tagged 8-bit samples, one per cycle, each carrying a channel index. For every channel it keeps a sliding window of the last WINDOW samples, a running sum and a fill count. Each accepted sample produces one result beat holding the updated windowed sum and average for that channel, delivered through a valid/ready handshake to the output/display logic.

## Interface
Parameters:
- NUM_CHANNELS, 14, number of independent channels.
- SAMPLE_BITS, 8, sample width.
- WINDOW, 10, window depth in samples; must be ≥ 2.
- Derived, not overridable:
  - CH_BITS = clog2(NUM_CHANNELS) = 4
  - SUM_BITS = SAMPLE_BITS + clog2(WINDOW) = 12
  - FILL_BITS = clog2(WINDOW+1) = 4

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush of all channel state.
- in_valid  in  1  input sample offered.
- in_ready  out  1  input can be accepted this cycle.
- in_channel  in  CH_BITS  channel index of the offered sample.
- in_sample  in  SAMPLE_BITS  unsigned sample value.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_channel  out  CH_BITS  channel the result belongs to.
- out_sum  out  SUM_BITS  windowed sum after the update.
- out_avg  out  SAMPLE_BITS  floor(out_sum / WINDOW).
- out_fill  out  FILL_BITS  samples currently in the window, 1..WINDOW.
- out_full  out  1  out_fill == WINDOW.
- chan_err  out  1  sticky flag: a sample with in_channel ≥ NUM_CHANNELS was accepted.

## Operation
**Per-channel state**
- History ring of WINDOW × SAMPLE_BITS.
- Write pointer, 0..WINDOW-1.
- Fill count, 0..WINDOW.
- Running sum, SUM_BITS wide.

**Handshake**
- in_ready = !reset && !clear && (!out_valid || out_ready).
- A sample is accepted when in_valid && in_ready.

**On accept, for a valid channel c**
- oldest = (fill[c] == WINDOW) ? hist[c][wp[c]] : 0.
- sum[c] ← sum[c] − oldest + in_sample. The result cannot overflow or underflow; the maximum value is WINDOW × (2^SAMPLE_BITS − 1) = 2550.
- hist[c][wp[c]] ← in_sample.
- wp[c] ← (wp[c] == WINDOW−1) ? 0 : wp[c]+1.
- fill[c] ← min(fill[c]+1, WINDOW).
- The output register loads channel c, the new sum, the new fill and the derived avg/full, and sets out_valid.

**Invalid channel**
- A sample with in_channel ≥ NUM_CHANNELS is accepted and discarded.
- No channel state changes and no output beat is produced.
- chan_err ← 1.

**Averaging**
- out_avg divides by the constant WINDOW, even while the window is filling. An unfilled window behaves as if padded with zeros.
- Consumers check out_full.

**Output register**
- Single entry.
- out_valid clears on out_valid && out_ready unless a new accept happens in the same cycle; a new accept overwrites the register and keeps out_valid high.
- While out_valid && !out_ready, all out_* fields hold stable.

**Clear** (when reset is low)
- Zeros every sum, fill and wp, and clears out_valid.
- History contents need not be cleared, because fill gates their use.
- chan_err is unaffected.
- in_ready is 0, so no sample is accepted in that cycle.

**Reset**
- Same effect as clear, and also clears chan_err.
- Takes priority over clear and in_valid.

## Timing
- Reset values: out_valid=0, out_channel=0, out_sum=0, out_avg=0, out_fill=0, out_full=0, chan_err=0, in_ready=0 during reset, and in_ready=1 in the first cycle after reset deasserts.
- Latency: a sample accepted at edge N appears on out_* with out_valid=1 immediately after edge N.
- Throughput: one sample per cycle while out_ready=1, including back-to-back samples on the same channel. State is updated at each edge, so there is no read-after-write hazard.
- Backpressure: when out_valid=1 and out_ready=0, in_ready drops combinationally in the same cycle.
- in_ready depends combinationally on out_ready, reset and clear. There is no combinational path from in_valid to out_*.
- A clear asserted together with in_valid drops the sample; the producer must hold it until in_ready=1.

## Test plan
1. **Reset:** assert reset for 2 cycles with in_valid=1 → no accept; all outputs 0; in_ready=1 on the first cycle after release.
2. **Fill and wrap:** ch3 receives samples 1..12 with out_ready=1.
   - Sums are 1, 3, 6, …, 55; at the 10th sample fill=10, full=1, avg=5.
   - 11th sample → sum=65, avg=6; 12th sample → sum=75, avg=7, with wp wrapped.
3. **Extremes and isolation:** ch0 and ch13 interleaved, ten 255s on ch0 and ten 0s on ch13.
   - Final ch0 beat: sum=2550, avg=255, full=1.
   - Final ch13 beat: sum=0.
   - A subsequent ch1 sample of 7 → sum=7, fill=1.
4. **Backpressure:** hold out_ready=0 and offer ch2=10 then ch2=20.
   - The first is accepted; in_ready goes 0; out_* stays stable for 5 cycles.
   - On release, the second is accepted in the same cycle and out_sum=30.
5. **Bad channel:** in_channel=14 with sample 99.
   - No out_valid; chan_err=1 and stays 1 after following ch5 traffic, which still produces correct sums.
   - Only reset clears chan_err.
6. **Clear mid-window:** ch4 holds 5 samples, then clear is asserted with in_valid=1 and sample 8.
   - The sample is not accepted and out_valid goes 0.
   - The next accepted ch4 sample of 8 → sum=8, fill=1, full=0.
